// File: rtl/moving_avg_filter.sv
// rtl/moving_avg_filter.sv - running-sum moving average anti-alias pre-filter
//
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   en        : block enable; low freezes all state and ignores flush
//   flush     : synchronous clear of window, sum and fill count (qualified by en)
//   valid_in  : data_in carries a new sample this cycle
//   data_in   : signed input sample
//   data_out  : signed rounded window mean, held between updates
//   valid_out : one-cycle pulse when data_out carries a primed result
//   primed    : high once a full window has been accepted since reset/flush

module moving_avg_filter #(
  parameter int Width     = 10,
  parameter int LOG2_TAPS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    flush,
  input  logic                    valid_in,
  input  logic signed [Width-1:0] data_in,
  output logic signed [Width-1:0] data_out,
  output logic                    valid_out,
  output logic                    primed
);

  localparam int N  = 1 << LOG2_TAPS;
  localparam int SW = Width + LOG2_TAPS;   // exact width for a sum of N samples
  localparam int FW = LOG2_TAPS + 1;       // fill counts 0..N inclusive

  localparam logic [FW-1:0]        FULL = FW'(N);
  localparam logic signed [SW:0]   HALF = (SW+1)'(N / 2);

  logic signed [Width-1:0] win [N];
  logic [LOG2_TAPS-1:0]    wr_ptr;
  logic [FW-1:0]           fill;
  logic [FW-1:0]           fill_next;
  logic signed [SW-1:0]    sum;
  logic signed [SW-1:0]    sum_next;
  logic signed [Width-1:0] oldest;
  logic signed [SW:0]      rounded;
  logic signed [Width-1:0] mean;
  logic                    acc;

  assign acc = en & valid_in & ~flush;

  // Slot at wr_ptr holds the sample leaving the window; read it before the
  // write on this edge replaces it. Unwritten slots are zero, which gives the
  // zero-padded warm-up averages.
  always_comb begin
    oldest    = win[wr_ptr];
    sum_next  = sum + SW'(data_in) - SW'(oldest);
    fill_next = (fill == FULL) ? fill : fill + 1'b1;
    // One extra bit so the rounding offset cannot overflow the sum; the
    // arithmetic shift then rounds half toward +inf and the result always
    // fits back in Width.
    rounded   = (SW+1)'(sum_next) + HALF;
    mean      = Width'(rounded >>> LOG2_TAPS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) win[i] <= '0;
      sum       <= '0;
      wr_ptr    <= '0;
      fill      <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (en && flush) begin
      // Flush outranks a simultaneous sample; that sample is dropped.
      for (int i = 0; i < N; i++) win[i] <= '0;
      sum       <= '0;
      wr_ptr    <= '0;
      fill      <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (acc) begin
      win[wr_ptr] <= data_in;
      sum         <= sum_next;
      wr_ptr      <= wr_ptr + 1'b1;   // power-of-two depth wraps for free
      fill        <= fill_next;
      data_out    <= mean;
      valid_out   <= (fill_next == FULL);
    end else begin
      valid_out <= 1'b0;
    end
  end

  // fill saturates at N, so it doubles as the FILLING/PRIMED state.
  assign primed = (fill == FULL);

endmodule

// File: tb/tb_moving_avg_filter.sv
// tb/tb_moving_avg_filter.sv - self-checking bench for moving_avg_filter

module tb_moving_avg_filter;

  localparam int W = 10;
  localparam int L = 3;
  localparam int N = 1 << L;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                en = 1'b0;
  logic                flush = 1'b0;
  logic                valid_in = 1'b0;
  logic signed [W-1:0] data_in = '0;
  logic signed [W-1:0] data_out;
  logic                valid_out;
  logic                primed;

  int checks = 0;
  int failures = 0;

  // Reference model: the last N accepted samples (zero padded), count of
  // accepted samples and the expected outputs.
  int q[$];
  int acc_cnt;
  int exp_data;
  bit exp_valid;

  moving_avg_filter #(.Width(W), .LOG2_TAPS(L)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .flush     (flush),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .primed    (primed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Mean rounded half toward +inf: floor((s + N/2) / N).
  function automatic int rmean(input int s);
    int num;
    num = s + N / 2;
    if (num >= 0) return num / N;
    return -((-num + N - 1) / N);
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < N; i++) q.push_back(0);
    acc_cnt   = 0;
    exp_data  = 0;
    exp_valid = 0;
  endtask

  task automatic model_apply(input bit e, input bit f, input bit v, input int d);
    int s;
    if (!rst_n) model_reset();
    else if (!e) exp_valid = 0;
    else if (f) model_reset();
    else if (v) begin
      q.push_back(d);
      void'(q.pop_front());
      if (acc_cnt < N) acc_cnt++;
      s = 0;
      foreach (q[i]) s += q[i];
      exp_data  = rmean(s);
      exp_valid = (acc_cnt == N);
    end else exp_valid = 0;
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, then
  // return at the falling edge where the compare process samples.
  task automatic step(input bit e, input bit f, input bit v, input int d);
    en       = e;
    flush    = f;
    valid_in = v;
    data_in  = W'(d);
    @(posedge clk);
    model_apply(e, f, v, d);
    @(negedge clk);
  endtask

  task automatic feed(input int d);
    step(1'b1, 1'b0, 1'b1, d);
  endtask

  always @(negedge clk) begin
    chk("cyc_data_out", int'(data_out), exp_data);
    chk("cyc_valid_out", int'(valid_out), int'(exp_valid));
    chk("cyc_primed", int'(primed), int'(acc_cnt == N));
  end

  initial begin
    int warm[7];
    warm = '{13, 25, 38, 50, 63, 75, 88};
    model_reset();

    // Reset held with random activity on the inputs.
    for (int i = 0; i < 6; i++)
      step(1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 1023) - 512);
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_valid_out", int'(valid_out), 0);
    chk("rst_primed", int'(primed), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 77);
    chk("idle_data_out", int'(data_out), 0);
    chk("idle_primed", int'(primed), 0);

    // Warm-up with a constant 100.
    for (int i = 0; i < 7; i++) begin
      feed(100);
      chk("warm_data_out", int'(data_out), warm[i]);
      chk("warm_model", exp_data, warm[i]);
      chk("warm_valid_out", int'(valid_out), 0);
    end
    feed(100);
    chk("prime_data_out", int'(data_out), 100);
    chk("prime_valid_out", int'(valid_out), 1);
    chk("prime_primed", int'(primed), 1);
    for (int i = 0; i < 3; i++) feed(100);
    chk("steady_data_out", int'(data_out), 100);

    // Rounding: windows summing to 4, -4, -5.
    feed(4);  for (int i = 0; i < 7; i++) feed(0);
    chk("round_p4", int'(data_out), 1);
    feed(-4); for (int i = 0; i < 7; i++) feed(0);
    chk("round_m4", int'(data_out), 0);
    feed(-5); for (int i = 0; i < 7; i++) feed(0);
    chk("round_m5", int'(data_out), -1);
    chk("round_m5_model", exp_data, -1);

    // Extremes.
    for (int i = 0; i < 8; i++) feed(511);
    chk("max_data_out", int'(data_out), 511);
    for (int i = 0; i < 8; i++) feed(-512);
    chk("min_data_out", int'(data_out), -512);

    // Wrap and sliding from a clean window.
    step(1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 8; i++) feed(i);
    chk("ramp_data_out", int'(data_out), 4);
    feed(8);
    chk("wrap_data_out", int'(data_out), 5);
    chk("wrap_valid_out", int'(valid_out), 1);

    // Enable low: nothing moves, flush ignored.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, i[0], 1'b1, 300 + i);
      chk("en_low_valid_out", int'(valid_out), 0);
    end
    chk("en_low_data_out", int'(data_out), 5);
    chk("en_low_primed", int'(primed), 1);

    // Flush together with a sample.
    step(1'b1, 1'b1, 1'b1, 200);
    chk("flush_data_out", int'(data_out), 0);
    chk("flush_primed", int'(primed), 0);
    for (int i = 0; i < 7; i++) feed(40);
    chk("refill7_valid_out", int'(valid_out), 0);
    feed(40);
    chk("refill8_valid_out", int'(valid_out), 1);
    chk("refill8_data_out", int'(data_out), 40);

    // Asynchronous reset mid-stream.
    feed(-40);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_data_out", int'(data_out), 0);
    chk("arst_valid_out", int'(valid_out), 0);
    chk("arst_primed", int'(primed), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) feed(-16);
    chk("post_rst7_valid_out", int'(valid_out), 0);
    chk("post_rst7_data_out", int'(data_out), -14);
    feed(-16);
    chk("post_rst8_valid_out", int'(valid_out), 1);
    chk("post_rst8_data_out", int'(data_out), -16);
    step(1'b1, 1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/moving_avg_filter.md
# moving_avg_filter

Anti-alias pre-filter placed directly upstream of the 2:1 down-sampler in the pre-processing chain. Each accepted sample goes into a 2^LOG2_TAPS-deep circular buffer, and the block keeps a running sum over that window. It outputs the rounded window mean with a one-cycle valid pulse. Connect `valid_out` to the down-sampler enable and `data_out` to its data input, so the down-sampler advances only on filtered samples.

## Interface
- `Width`, 10, sample width (signed two's complement) for both input and output.
- `LOG2_TAPS`, 3, log2 of the window length (taps N = 2^LOG2_TAPS); legal range 1..5.

- `clk`  in  1  clock; all logic is rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  block enable; when low, all state is frozen.
- `flush`  in  1  synchronous clear of the buffer, sum and fill count.
- `valid_in`  in  1  `data_in` is a new sample this cycle.
- `data_in`  in  Width  signed input sample.
- `data_out`  out  Width  signed rounded window mean; holds its value between updates.
- `valid_out`  out  1  one-cycle pulse when `data_out` is updated with a primed result.
- `primed`  out  1  high once N samples have been accepted since reset or flush.

## Operation
- **Accept condition:** `acc = en & valid_in & ~flush`.
- **On acc:**
  - `buf[wr_ptr] <= data_in`.
  - `sum <= sum + data_in - buf[wr_ptr]`, where `buf[wr_ptr]` is the oldest sample, read before it is overwritten.
  - `wr_ptr <= wr_ptr + 1`, wrapping modulo N.
  - `fill` increments, saturating at N.
- **Sum width:** `sum` is signed Width+LOG2_TAPS bits. It is exact and never overflows.
- **Mean:**
  - `mean = (sum_next + 2^(LOG2_TAPS-1)) >>> LOG2_TAPS`, computed at Width+LOG2_TAPS+1 bits (arithmetic shift, round half toward +inf), then truncated to Width.
  - The result always fits in Width: max (N·(2^(W-1)-1)+N/2)>>>L = 2^(W-1)-1; min = -2^(W-1).
- **Output update on acc:** `data_out <= mean` regardless of fill state.
  - `valid_out <= 1` only if `fill_next == N`, i.e. starting with the Nth accepted sample.
- **Warm-up:**
  - The buffer resets to zeros, so pre-primed means are zero-padded averages.
  - `valid_out` is suppressed until primed.
- **Flush** (`en & flush`):
  - Clears all buffer entries, `sum`, `wr_ptr`, `fill`, `primed`, `valid_out` and `data_out` to 0 on the next edge.
  - Flush wins over a simultaneous `valid_in`; that sample is dropped.
- **`en` low:** no state changes, `flush` is ignored, and `valid_out <= 0`. `data_out` and `primed` hold.
- **`valid_in` low with `en` high:** `valid_out <= 0`; everything else holds.
- **State:** there is no separate FSM. `fill` (0..N) carries two states:
  - FILLING (`fill < N`) moves to PRIMED when the Nth sample is accepted.
  - PRIMED moves back to FILLING on flush or reset.

## Timing
- **Reset values:** `data_out = 0`, `valid_out = 0`, `primed = 0`. Internal buffer, `sum`, `wr_ptr` and `fill` are all 0.
- **Latency:** one cycle. A sample accepted at edge k produces `data_out` and `valid_out` after edge k.
- **Throughput:** one sample per clock; `valid_in` may be high every cycle.
- **`valid_out`:** never high for two consecutive cycles unless `acc` is high on consecutive cycles.
- **`primed`:** rises on the same edge as the first `valid_out` and stays high until flush or reset.
- **Reset mid-operation:** asserting `rst_n` low at any time returns all state to reset values immediately. The first sample after release starts a fresh fill.

## Test plan
- **Reset:** hold `rst_n` low, drive random inputs -> `data_out = 0`, `valid_out = 0`, `primed = 0`. After release with `valid_in = 0` -> all remain 0.
- **Warm-up (N=8):** feed 100 on consecutive cycles.
  - Samples 1-7 -> `valid_out = 0`; `data_out` = 13, 25, 38, 50, 63, 75, 88.
  - Sample 8 -> `valid_out = 1`, `data_out = 100`, `primed = 1`.
  - Further 100s -> `data_out` stays at 100.
- **Rounding and extremes (after priming):**
  - Window sum 4 -> mean 1; sum -4 -> mean 0; sum -5 -> mean -1.
  - All 511 -> 511; all -512 -> -512; no wrap.
- **Wrap and sliding:** prime with 0..7, then feed 8 -> sum = 36, `data_out = 5`. The oldest value (0) is replaced, confirming `wr_ptr` wrap.
- **Enable and flush:**
  - Drop `en` for 5 cycles with `valid_in = 1` -> no `valid_out`; `data_out` and `primed` hold.
  - Assert flush together with `valid_in` -> sample dropped; `primed = 0` and `data_out = 0` next cycle. Eight more samples are required before the next `valid_out`.
- **Reset mid-stream:** pulse `rst_n` low while primed -> outputs go to 0 asynchronously. A new fill of eight samples is required before `valid_out`.
